// File: rtl/fex_issue_ctrl_pkg.sv
// FEX issue sequencer shared types.
// Op classes, FSM states and the writeback tag bundle.
package fex_issue_ctrl_pkg;

  localparam int REGFILE_DEPTH = 5;
  localparam int FEX_CNT_W = 4;

  typedef enum logic [2:0] {
    FEX_ADD,
    FEX_MUL,
    FEX_DIV,
    FEX_CVT
  } fex_op_e;

  typedef enum logic {
    FEX_IDLE,
    FEX_EXEC
  } fex_st_e;

  typedef struct packed {
    logic [REGFILE_DEPTH-1:0] regw;
    logic                     ctrl_regw;
    logic [1:0]               cvt;
  } fex_tag_t;

endpackage

// File: rtl/fex_issue_ctrl_if.sv
// Issue/writeback bundle between ID/FEX and the FEX sequencer.
// master = decode side, slave = sequencer.
interface fex_issue_ctrl_if;
  import fex_issue_ctrl_pkg::*;

  logic                     issue_valid;
  fex_op_e                  issue_op;
  logic [REGFILE_DEPTH-1:0] issue_regw;
  logic                     issue_ctrl_regw;
  logic [1:0]               issue_FPIntCvtReg;
  logic                     flush;
  logic                     issue_ready;
  logic                     FEX_busy;
  logic                     FEX_busy_er;
  logic                     fex_start;
  logic                     wb_valid;
  logic [REGFILE_DEPTH-1:0] wb_regw;
  logic                     wb_ctrl_regw;
  logic [1:0]               wb_FPIntCvtReg;
  logic                     issue_err;

  modport master (
    output issue_valid, issue_op, issue_regw,
    output issue_ctrl_regw, issue_FPIntCvtReg, flush,
    input  issue_ready, FEX_busy, FEX_busy_er,
    input  fex_start, wb_valid, wb_regw,
    input  wb_ctrl_regw, wb_FPIntCvtReg, issue_err
  );

  modport slave (
    input  issue_valid, issue_op, issue_regw,
    input  issue_ctrl_regw, issue_FPIntCvtReg, flush,
    output issue_ready, FEX_busy, FEX_busy_er,
    output fex_start, wb_valid, wb_regw,
    output wb_ctrl_regw, wb_FPIntCvtReg, issue_err
  );

endinterface

// File: rtl/fex_lat_lut.sv
// Op class to execute latency lookup.
// Unknown encodings fall back to the add latency.
module fex_lat_lut
  import fex_issue_ctrl_pkg::*;
#(
  parameter logic [FEX_CNT_W-1:0] ADD_LAT = 4'd3,
  parameter logic [FEX_CNT_W-1:0] MUL_LAT = 4'd4,
  parameter logic [FEX_CNT_W-1:0] DIV_LAT = 4'd12,
  parameter logic [FEX_CNT_W-1:0] CVT_LAT = 4'd2
) (
  input  fex_op_e              op,
  output logic [FEX_CNT_W-1:0] lat
);

  always_comb begin
    lat = ADD_LAT;
    case (op)
      FEX_MUL: lat = MUL_LAT;
      FEX_DIV: lat = DIV_LAT;
      FEX_CVT: lat = CVT_LAT;
      default: lat = ADD_LAT;
    endcase
  end

endmodule

// File: rtl/fex_issue_ctrl.sv
// FEX issue/occupancy sequencer: latency countdown,
// busy/early-release status and writeback tag.
module fex_issue_ctrl
  import fex_issue_ctrl_pkg::*;
#(
  parameter logic [FEX_CNT_W-1:0] ADD_LAT = 4'd3,
  parameter logic [FEX_CNT_W-1:0] MUL_LAT = 4'd4,
  parameter logic [FEX_CNT_W-1:0] DIV_LAT = 4'd12,
  parameter logic [FEX_CNT_W-1:0] CVT_LAT = 4'd2
) (
  input logic             clk,
  input logic             rst_n,
  fex_issue_ctrl_if.slave bus
);

  fex_st_e              st;
  logic [FEX_CNT_W-1:0] cnt;
  logic [FEX_CNT_W-1:0] lat;
  fex_tag_t             tag;
  logic                 err;
  logic                 busy;
  logic                 last;
  logic                 acc;
  logic                 wb_v;

  fex_lat_lut #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CVT_LAT(CVT_LAT)
  ) u_lut (
    .op (bus.issue_op),
    .lat(lat)
  );

  assign busy = (st == FEX_EXEC);
  assign last = busy & (cnt == FEX_CNT_W'(1));
  assign acc  = bus.issue_valid & ~bus.flush
              & (~busy | last);
  // A flush squashes the op that would retire now.
  assign wb_v = last & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= FEX_IDLE;
      cnt <= '0;
      tag <= '0;
      err <= 1'b0;
    end else begin
      if (bus.issue_valid & busy & ~last)
        err <= 1'b1;
      if (bus.flush) begin
        st  <= FEX_IDLE;
        cnt <= '0;
      end else if (acc) begin
        st  <= FEX_EXEC;
        cnt <= lat;
        tag <= '{regw:      bus.issue_regw,
                 ctrl_regw: bus.issue_ctrl_regw,
                 cvt:       bus.issue_FPIntCvtReg};
      end else if (last) begin
        st  <= FEX_IDLE;
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt - FEX_CNT_W'(1);
      end
    end
  end

  assign bus.issue_ready    = acc;
  assign bus.fex_start      = acc;
  assign bus.FEX_busy       = busy;
  assign bus.FEX_busy_er    = last;
  assign bus.wb_valid       = wb_v;
  assign bus.wb_regw        = wb_v ? tag.regw : '0;
  assign bus.wb_ctrl_regw   = wb_v & tag.ctrl_regw;
  assign bus.wb_FPIntCvtReg = wb_v ? tag.cvt : 2'b00;
  assign bus.issue_err      = err;

endmodule

// File: tb/tb_fex_issue_ctrl.sv
// Directed and scoreboarded checks for fex_issue_ctrl.
module tb_fex_issue_ctrl;
  import fex_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  fex_issue_ctrl_if bus ();

  fex_issue_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] regw;
    logic       ctrl;
    logic [1:0] cvt;
    int         cyc;
    int         lat;
  } ent_t;

  ent_t q[$];

  function automatic int latf(input logic [2:0] op);
    case (op)
      3'd1:    return 4;
      3'd2:    return 12;
      3'd3:    return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic v,
                      input logic [2:0] op,
                      input logic [4:0] r,
                      input logic c,
                      input logic [1:0] cv,
                      input logic fl);
    @(negedge clk);
    bus.issue_valid       = v;
    bus.issue_op          = fex_op_e'(op);
    bus.issue_regw        = r;
    bus.issue_ctrl_regw   = c;
    bus.issue_FPIntCvtReg = cv;
    bus.flush             = fl;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 5'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_err", bus.issue_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int mcnt;
    int acc_n;
    int cyc;
    int nwb;
    logic v;
    logic [2:0] op;
    logic [4:0] r;
    logic c;
    logic [1:0] cv;
    ent_t e;

    bus.issue_valid       = 1'b0;
    bus.issue_op          = FEX_ADD;
    bus.issue_regw        = '0;
    bus.issue_ctrl_regw   = 1'b0;
    bus.issue_FPIntCvtReg = 2'b00;
    bus.flush             = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.FEX_busy, 0);
    chk("rst_er", bus.FEX_busy_er, 0);
    chk("rst_wb", bus.wb_valid, 0);
    chk("rst_ready", bus.issue_ready, 0);
    chk("rst_start", bus.fex_start, 0);
    chk("rst_err0", bus.issue_err, 0);
    chk("rst_wbregw", bus.wb_regw, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single MUL, regw=7
    step(1'b1, 3'd1, 5'd7, 1'b1, 2'b00, 1'b0);
    chk("mul_ready", bus.issue_ready, 1);
    chk("mul_start", bus.fex_start, 1);
    chk("mul_busy0", bus.FEX_busy, 0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk($sformatf("mul_busy%0d", k), bus.FEX_busy, 1);
      chk($sformatf("mul_er%0d", k),
          bus.FEX_busy_er, (k == 4));
      chk($sformatf("mul_wb%0d", k),
          bus.wb_valid, (k == 4));
    end
    chk("mul_wbregw", bus.wb_regw, 7);
    chk("mul_wbctrl", bus.wb_ctrl_regw, 1);
    idle();
    chk("mul_busy5", bus.FEX_busy, 0);
    chk("mul_wb5", bus.wb_valid, 0);

    // ADD then CVT issued back-to-back in the release cycle
    step(1'b1, 3'd0, 5'd9, 1'b1, 2'b01, 1'b0);
    chk("ac_ready0", bus.issue_ready, 1);
    for (int k = 1; k <= 2; k++) begin
      idle();
      chk($sformatf("ac_ready%0d", k), bus.issue_ready, 0);
      chk($sformatf("ac_busy%0d", k), bus.FEX_busy, 1);
      chk($sformatf("ac_er%0d", k), bus.FEX_busy_er, 0);
      chk($sformatf("ac_err%0d", k), bus.issue_err, 0);
    end
    step(1'b1, 3'd3, 5'd3, 1'b1, 2'b10, 1'b0);
    chk("ac_ready3", bus.issue_ready, 1);
    chk("ac_er3", bus.FEX_busy_er, 1);
    chk("ac_wb3", bus.wb_valid, 1);
    chk("ac_wbregw3", bus.wb_regw, 9);
    chk("ac_wbcvt3", bus.wb_FPIntCvtReg, 2'b01);
    idle();
    chk("ac_busy4", bus.FEX_busy, 1);
    chk("ac_wb4", bus.wb_valid, 0);
    idle();
    chk("ac_busy5", bus.FEX_busy, 1);
    chk("ac_wb5", bus.wb_valid, 1);
    chk("ac_wbregw5", bus.wb_regw, 3);
    chk("ac_wbcvt5", bus.wb_FPIntCvtReg, 2'b10);
    idle();
    chk("ac_busy6", bus.FEX_busy, 0);
    chk("ac_err6", bus.issue_err, 0);

    // protocol violation: valid during busy & ~er
    step(1'b1, 3'd1, 5'd5, 1'b1, 2'b00, 1'b0);
    step(1'b1, 3'd0, 5'd12, 1'b0, 2'b11, 1'b0);
    chk("pv_ready", bus.issue_ready, 0);
    idle();
    chk("pv_err", bus.issue_err, 1);
    idle();
    idle();
    chk("pv_wb", bus.wb_valid, 1);
    chk("pv_wbregw", bus.wb_regw, 5);
    chk("pv_wbctrl", bus.wb_ctrl_regw, 1);
    chk("pv_wbcvt", bus.wb_FPIntCvtReg, 2'b00);
    idle();
    chk("pv_idle", bus.FEX_busy, 0);
    chk("pv_sticky", bus.issue_err, 1);
    pulse_rst();

    // out-of-enum op runs with the add latency
    step(1'b1, 3'd6, 5'd2, 1'b1, 2'b00, 1'b0);
    idle();
    idle();
    chk("bad_er2", bus.FEX_busy_er, 0);
    idle();
    chk("bad_wb3", bus.wb_valid, 1);
    idle();
    chk("bad_busy4", bus.FEX_busy, 0);

    // flush in the retire cycle of a DIV
    step(1'b1, 3'd2, 5'd4, 1'b1, 2'b00, 1'b0);
    for (int k = 1; k <= 11; k++) idle();
    chk("fl_er11", bus.FEX_busy_er, 0);
    step(1'b1, 3'd0, 5'd8, 1'b1, 2'b00, 1'b1);
    chk("fl_wb", bus.wb_valid, 0);
    chk("fl_ready", bus.issue_ready, 0);
    chk("fl_start", bus.fex_start, 0);
    idle();
    chk("fl_busy", bus.FEX_busy, 0);
    chk("fl_wb2", bus.wb_valid, 0);
    chk("fl_err", bus.issue_err, 0);

    // async reset mid-EXEC drops the op
    step(1'b1, 3'd2, 5'd11, 1'b1, 2'b01, 1'b0);
    for (int k = 1; k <= 8; k++) idle();
    rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.FEX_busy, 0);
    chk("ar_er", bus.FEX_busy_er, 0);
    chk("ar_wb", bus.wb_valid, 0);
    chk("ar_wbregw", bus.wb_regw, 0);
    chk("ar_wbcvt", bus.wb_FPIntCvtReg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nwb = 0;
    for (int k = 0; k < 15; k++) begin
      idle();
      if (bus.wb_valid) nwb++;
    end
    chk("ar_nowb", nwb, 0);

    // random back-to-back mix against a scoreboard
    mcnt  = 0;
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 1000 && cyc < 20000) begin
      v  = (mcnt <= 1) && ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      r  = 5'($urandom);
      c  = 1'($urandom);
      cv = 2'($urandom);
      step(v, op, r, c, cv, 1'b0);
      chk("rnd_ready", bus.issue_ready, v);
      chk("rnd_busy", bus.FEX_busy, (mcnt != 0));
      chk("rnd_er", bus.FEX_busy_er, (mcnt == 1));
      chk("rnd_wb", bus.wb_valid, (mcnt == 1));
      if (bus.issue_ready)
        chk("rnd_noviol",
            bus.FEX_busy & ~bus.FEX_busy_er, 0);
      if (mcnt == 1) begin
        if (q.size() == 0) begin
          chk("rnd_qempty", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_regw", bus.wb_regw, e.regw);
          chk("rnd_ctrl", bus.wb_ctrl_regw, e.ctrl);
          chk("rnd_cvt", bus.wb_FPIntCvtReg, e.cvt);
          chk("rnd_lat", cyc - e.cyc, e.lat);
        end
      end
      if (v) begin
        q.push_back('{r, c, cv, cyc, latf(op)});
        mcnt = latf(op);
        acc_n++;
      end else if (mcnt > 0) begin
        mcnt--;
      end
      cyc++;
    end
    chk("rnd_done", (acc_n >= 1000), 1);
    chk("rnd_err", bus.issue_err, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
